// File: rtl/fir_pkg.sv
// Shared constants, FSM state type and sizing helpers for the FIR filter.
// FIR_WL/FIR_TAPS are the default word length and tap count. FIR_FRAC is the
// number of fractional bits of the signed Q1.(WL-1) format. FIR_SAT_MAX and
// FIR_SAT_MIN are the output clip limits for the default word length.
package fir_pkg;

    localparam int unsigned FIR_WL      = 8;
    localparam int unsigned FIR_TAPS    = 3;
    localparam int unsigned FIR_FRAC    = FIR_WL - 1;
    localparam int          FIR_SAT_MAX = (1 << FIR_FRAC) - 1;
    localparam int          FIR_SAT_MIN = -(1 << FIR_FRAC);

    // Coefficient-load phase, then sample streaming until the next reset.
    typedef enum logic [0:0] {
        StLoad,
        StRun
    } fir_state_e;

    function automatic int unsigned frac_bits(int unsigned wl);
        return wl - 1;
    endfunction

    function automatic int sat_max(int unsigned wl);
        return (1 << frac_bits(wl)) - 1;
    endfunction

    function automatic int sat_min(int unsigned wl);
        return -(1 << frac_bits(wl));
    endfunction

    // Full-precision products plus headroom for summing taps products.
    function automatic int unsigned acc_width(int unsigned wl, int unsigned taps);
        return 2 * wl + $clog2(taps);
    endfunction

endpackage

// File: rtl/fir_if.sv
// Sample/coefficient bus of the FIR filter.
//   enable  : qualifies x/h for the current cycle
//   x       : signed sample input
//   h       : signed coefficient input
//   y       : signed, registered filter output
//   y_valid : one-cycle pulse per new y
// master drives enable/x/h (the source); slave is the filter.
interface fir_if
    import fir_pkg::*;
#(
    parameter int unsigned WL = FIR_WL
) ();

    logic                 enable;
    logic signed [WL-1:0] x;
    logic signed [WL-1:0] h;
    logic signed [WL-1:0] y;
    logic                 y_valid;

    modport master (
        output enable,
        output x,
        output h,
        input  y,
        input  y_valid
    );

    modport slave (
        input  enable,
        input  x,
        input  h,
        output y,
        output y_valid
    );

endinterface

// File: rtl/fir_tap.sv
// One FIR tap: coefficient register, delay register and signed multiplier.
//   clk, reset  : clock and asynchronous active-low reset
//   coef_load_i : capture coef_i into the coefficient register
//   coef_i      : coefficient value
//   shift_i     : advance the delay line (capture sample_i)
//   sample_i    : sample entering this tap (x for tap 0, previous tap's delay otherwise)
//   sample_o    : delayed sample, feeds the next tap
//   prod_o      : coef * sample_i, full 2*WL precision
// The product uses sample_i rather than the stored delay so the output reflects
// the sample being accepted on this same edge.
module fir_tap
    import fir_pkg::*;
#(
    parameter int unsigned WL = FIR_WL
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   coef_load_i,
    input  logic signed [WL-1:0]   coef_i,
    input  logic                   shift_i,
    input  logic signed [WL-1:0]   sample_i,
    output logic signed [WL-1:0]   sample_o,
    output logic signed [2*WL-1:0] prod_o
);

    logic signed [WL-1:0] coef_q, coef_d;
    logic signed [WL-1:0] dly_q, dly_d;

    always_comb begin
        coef_d = coef_q;
        dly_d  = dly_q;
        if (coef_load_i) begin
            coef_d = coef_i;
        end
        if (shift_i) begin
            dly_d = sample_i;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            coef_q <= '0;
            dly_q  <= '0;
        end else begin
            coef_q <= coef_d;
            dly_q  <= dly_d;
        end
    end

    assign sample_o = dly_q;
    assign prod_o   = coef_q * sample_i;

endmodule

// File: rtl/fir_filter.sv
// Direct-form FIR filter with serially loaded coefficients.
//   clk   : clock, all state changes on the rising edge
//   reset : asynchronous active-low reset; clears coefficients, delay line,
//           load counter and output, and restarts the coefficient-load phase
//   bus   : fir_if slave port (enable, x, h in; y, y_valid out)
// After reset the first TAPS enabled cycles load h into coef[0..TAPS-1]. Every
// later enabled cycle shifts x into the delay line and registers the saturated,
// Q1.(WL-1)-rescaled dot product, pulsing y_valid alongside it.
module fir_filter
    import fir_pkg::*;
#(
    parameter int unsigned WL   = FIR_WL,
    parameter int unsigned TAPS = FIR_TAPS
) (
    input logic  clk,
    input logic  reset,
    fir_if.slave bus
);

    localparam int unsigned ProdW = 2 * WL;
    localparam int unsigned AccW  = acc_width(WL, TAPS);
    localparam int unsigned CntW  = (TAPS > 1) ? $clog2(TAPS) : 1;

    localparam logic signed [AccW-1:0] SatHi = AccW'(sat_max(WL));
    localparam logic signed [AccW-1:0] SatLo = AccW'(sat_min(WL));

    fir_state_e state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic signed [WL-1:0] y_q, y_d;
    logic y_valid_q, y_valid_d;

    logic load_en;
    logic shift_en;

    logic signed [WL-1:0]    tap_in  [TAPS];
    logic signed [WL-1:0]    tap_out [TAPS];
    logic signed [ProdW-1:0] prod    [TAPS];

    logic signed [AccW-1:0] acc;
    logic signed [AccW-1:0] acc_sh;
    logic signed [WL-1:0]   y_sat;

    // Tap chain: tap 0 sees the incoming sample, tap k sees d[k-1].
    for (genvar k = 0; k < TAPS; k++) begin : g_tap
        if (k == 0) begin : g_first
            assign tap_in[k] = bus.x;
        end else begin : g_rest
            assign tap_in[k] = tap_out[k-1];
        end

        fir_tap #(
            .WL (WL)
        ) u_tap (
            .clk         (clk),
            .reset       (reset),
            .coef_load_i (load_en && (cnt_q == CntW'(k))),
            .coef_i      (bus.h),
            .shift_i     (shift_en),
            .sample_i    (tap_in[k]),
            .sample_o    (tap_out[k]),
            .prod_o      (prod[k])
        );
    end

    // Load-phase sequencing. The counter only indexes coefficients, so it is
    // parked at zero once streaming starts; only a reset leaves StRun.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        load_en  = 1'b0;
        shift_en = 1'b0;
        case (state_q)
            StLoad: begin
                if (bus.enable) begin
                    load_en = 1'b1;
                    if (cnt_q == CntW'(TAPS - 1)) begin
                        state_d = StRun;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            StRun: begin
                shift_en = bus.enable;
            end
            default: begin
                state_d = StLoad;
                cnt_d   = '0;
            end
        endcase
    end

    // Sum of products, rescale by the fractional bits (floor), then clip.
    always_comb begin
        acc = '0;
        for (int k = 0; k < TAPS; k++) begin
            acc = acc + AccW'(prod[k]);
        end
        acc_sh = acc >>> (WL - 1);
        if (acc_sh > SatHi) begin
            y_sat = SatHi[WL-1:0];
        end else if (acc_sh < SatLo) begin
            y_sat = SatLo[WL-1:0];
        end else begin
            y_sat = acc_sh[WL-1:0];
        end
    end

    always_comb begin
        y_d       = y_q;
        y_valid_d = 1'b0;
        if (shift_en) begin
            y_d       = y_sat;
            y_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StLoad;
            cnt_q     <= '0;
            y_q       <= '0;
            y_valid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            y_q       <= y_d;
            y_valid_q <= y_valid_d;
        end
    end

    assign bus.y       = y_q;
    assign bus.y_valid = y_valid_q;

endmodule

// File: tb/tb_fir_filter.sv
// Self-checking bench for fir_filter (WL=8, TAPS=3).
module tb_fir_filter;
    import fir_pkg::*;

    localparam int unsigned WL   = 8;
    localparam int unsigned TAPS = 3;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    fir_if #(.WL(WL)) bus ();

    fir_filter #(
        .WL   (WL),
        .TAPS (TAPS)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       en;
        logic [7:0] x;
        logic [7:0] h;
        logic       vld;
        logic [7:0] y;
    } vec_t;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] sb_q[$];
    logic [7:0] y_hold = 8'h00;

    logic [7:0] hs [3] = '{8'hEB, 8'h33, 8'h1A};
    logic [7:0] xs [5] = '{8'h0D, 8'hE6, 8'h26, 8'hCD, 8'h00};
    logic [7:0] ys [5] = '{8'hFD, 8'h09, 8'hF2, 8'h12, 8'hF3};

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h, expected %02h", name, act, exp);
        end
    endtask

    // One clock: drive at negedge, sample 1 ns after the rising edge.
    task automatic cycle(input string name, input logic en, input logic [7:0] xv,
                         input logic [7:0] hv, input logic vld, input logic [7:0] ey);
        logic [7:0] e;
        @(negedge clk);
        bus.enable = en;
        bus.x      = xv;
        bus.h      = hv;
        if (vld) sb_q.push_back(ey);
        @(posedge clk);
        #1;
        check($sformatf("%s y_valid", name), {7'd0, bus.y_valid}, {7'd0, vld});
        if (bus.y_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL %s: y_valid with empty scoreboard, got y=%02h, expected none",
                         name, bus.y);
            end else begin
                e = sb_q.pop_front();
                check($sformatf("%s y", name), bus.y, e);
                y_hold = e;
            end
        end else begin
            if (vld && sb_q.size() != 0) void'(sb_q.pop_back());
            check($sformatf("%s y held", name), bus.y, y_hold);
        end
    endtask

    task automatic do_reset(input string name);
        @(negedge clk);
        bus.enable = 1'b0;
        reset      = 1'b0;
        #1;
        check($sformatf("%s y", name), bus.y, 8'h00);
        check($sformatf("%s y_valid", name), {7'd0, bus.y_valid}, 8'h00);
        sb_q.delete();
        y_hold = 8'h00;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic load_std();
        for (int i = 0; i < 3; i++) begin
            cycle($sformatf("load%0d", i), 1'b1, 8'($urandom), hs[i], 1'b0, 8'h00);
        end
    endtask

    vec_t tbl [8];

    initial begin
        bus.enable = 1'b0;
        bus.x      = '0;
        bus.h      = '0;

        // Reference stream: load phase (x is garbage, must be ignored), then samples.
        tbl[0] = '{1'b1, 8'h55, 8'hEB, 1'b0, 8'h00};
        tbl[1] = '{1'b1, 8'hAA, 8'h33, 1'b0, 8'h00};
        tbl[2] = '{1'b1, 8'h7F, 8'h1A, 1'b0, 8'h00};
        tbl[3] = '{1'b1, 8'h0D, 8'h00, 1'b1, 8'hFD};
        tbl[4] = '{1'b1, 8'hE6, 8'h11, 1'b1, 8'h09};
        tbl[5] = '{1'b1, 8'h26, 8'h22, 1'b1, 8'hF2};
        tbl[6] = '{1'b1, 8'hCD, 8'h33, 1'b1, 8'h12};
        tbl[7] = '{1'b1, 8'h00, 8'h44, 1'b1, 8'hF3};

        do_reset("por");
        for (int i = 0; i < 8; i++) begin
            cycle($sformatf("vec%0d", i), tbl[i].en, tbl[i].x, tbl[i].h, tbl[i].vld, tbl[i].y);
        end

        // Saturation: all coefficients -1.0.
        do_reset("sat rst");
        for (int i = 0; i < 3; i++) cycle("sat load", 1'b1, 8'h00, 8'h80, 1'b0, 8'h00);
        cycle("sat p1", 1'b1, 8'h80, 8'h00, 1'b1, 8'h7F);
        cycle("sat p2", 1'b1, 8'h80, 8'h00, 1'b1, 8'h7F);
        cycle("sat p3", 1'b1, 8'h80, 8'h00, 1'b1, 8'h7F);
        cycle("sat f1", 1'b1, 8'h00, 8'h00, 1'b1, 8'h7F);
        cycle("sat f2", 1'b1, 8'h00, 8'h00, 1'b1, 8'h7F);
        cycle("sat f3", 1'b1, 8'h00, 8'h00, 1'b1, 8'h00);
        cycle("sat n1", 1'b1, 8'h7F, 8'h00, 1'b1, 8'h81);
        cycle("sat n2", 1'b1, 8'h7F, 8'h00, 1'b1, 8'h80);
        cycle("sat n3", 1'b1, 8'h7F, 8'h00, 1'b1, 8'h80);

        // Enable gaps: garbage on x/h while enable is low must change nothing.
        do_reset("gap rst");
        for (int i = 0; i < 3; i++) begin
            cycle("gap load", 1'b1, 8'h00, hs[i], 1'b0, 8'h00);
            cycle("gap lidle", 1'b0, 8'($urandom), 8'($urandom), 1'b0, 8'h00);
        end
        for (int i = 0; i < 5; i++) begin
            cycle($sformatf("gap s%0d", i), 1'b1, xs[i], 8'($urandom), 1'b1, ys[i]);
            cycle("gap idle", 1'b0, 8'($urandom), 8'($urandom), 1'b0, 8'h00);
            cycle("gap idle", 1'b0, 8'($urandom), 8'($urandom), 1'b0, 8'h00);
        end

        // Reset mid-load: next enabled cycle must be coefficient 0 again.
        do_reset("ml rst");
        cycle("ml load", 1'b1, 8'h00, 8'h40, 1'b0, 8'h00);
        cycle("ml load", 1'b1, 8'h00, 8'h40, 1'b0, 8'h00);
        do_reset("ml rst2");
        load_std();
        cycle("ml s0", 1'b1, xs[0], 8'h00, 1'b1, ys[0]);

        // Reset mid-stream: delay line cleared, outputs restart at 0xFD.
        do_reset("ms rst");
        load_std();
        cycle("ms a0", 1'b1, xs[0], 8'h00, 1'b1, ys[0]);
        cycle("ms a1", 1'b1, xs[1], 8'h00, 1'b1, ys[1]);
        do_reset("ms rst2");
        load_std();
        for (int i = 0; i < 5; i++) begin
            cycle($sformatf("ms b%0d", i), 1'b1, xs[i], 8'h00, 1'b1, ys[i]);
        end

        n_tests++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard drain: got %0d pending, expected 0", sb_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
